seven_seg_scan_driver: RTL
==========================

Name: seven_seg_scan_driver

Overview:
- Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display with shared segment lines.
- Takes a packed hex value (4 bits per digit) and scans the digits one at a time, each with a dead-time gap to prevent ghosting.
- New values are double-buffered and committed only at frame boundaries, so a frame never tears.
- Sits between counter/UART/debug logic and the board's segment and digit-select pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned (2..8).
- CLKS_PER_DIGIT, 25000, drive cycles per digit slot (>=2).
- DEAD_CLKS, 250, blank cycles before each digit slot (>=1).
- SEG_ACTIVE_LOW, 1, 1 = segment pins are low-true.
- DIG_ACTIVE_LOW, 1, 1 = digit-enable pins are low-true.

Ports:
- i_Clk  in  1  system clock
- i_Rst_L  in  1  async active-low reset
- i_Value  in  4*NUM_DIGITS  packed hex digits, digit 0 = bits [3:0] (least significant)
- i_Load  in  1  one-cycle strobe capturing i_Value and i_Blank_Mask
- i_Blank_Mask  in  NUM_DIGITS  1 = force that digit dark
- o_Segments  out  7  segment drive, bit6=A ... bit0=G (logical encoding, then polarity applied)
- o_Digit_En  out  NUM_DIGITS  one-hot digit select (polarity applied)
- o_Frame_Done  out  1  one-cycle pulse in the final drive cycle of digit NUM_DIGITS-1

Behaviour:
- Interface clocking is fixed: one clock, i_Clk; reset i_Rst_L is asynchronous and active-low.
- Reset (async assert, sync release) sets:
  - state=BLANK, digit index=0, cycle counter=0;
  - display and pending registers=0, pending_valid=0, display blank mask=0;
  - o_Segments all-off (all 1 if SEG_ACTIVE_LOW), o_Digit_En all-off, o_Frame_Done=0.
- Hex encoding (logical, A..G = bit6..0):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70;
  - 8=7F, 9=7B, A=77, b=1F, C=4E, d=3D, E=4F, F=47.
- FSM:
  - BLANK: all digits off, segments off. Counter runs 0..DEAD_CLKS-1, then -> DRIVE with counter cleared.
  - DRIVE: o_Digit_En one-hot on the current index. o_Segments = encoding of the display nibble, or all-off if that digit's display-mask bit is 1. Counter runs 0..CLKS_PER_DIGIT-1, then -> BLANK and index advances.
  - Index wraps NUM_DIGITS-1 -> 0.
- Outputs are registered: they reflect the state/index in the same cycle the state register holds them, with no extra pipeline stage. Segments and digit enable change in the same edge.
- Slot and frame timing:
  - Slot length = DEAD_CLKS + CLKS_PER_DIGIT.
  - Frame = NUM_DIGITS * slot.
  - After reset release, the first digit-0 drive cycle is edge DEAD_CLKS+1.
- Loading and commit:
  - i_Load captures i_Value and i_Blank_Mask into the pending registers and sets pending_valid.
  - A later i_Load overwrites pending; last writer wins.
- Commit happens on the wrap edge: last DRIVE cycle of digit NUM_DIGITS-1 -> BLANK of digit 0.
  - If pending_valid, then display <= pending and pending_valid <= 0.
  - If i_Load arrives in that same cycle, the incoming value is committed directly and pending_valid stays 0.
- o_Frame_Done pulses in exactly that wrap cycle, once per frame.
- The counter width is computed from the larger of CLKS_PER_DIGIT and DEAD_CLKS. The counter never exceeds its terminal value.
- Reset mid-frame immediately blanks all outputs and discards the pending value.

Optional Feature:
- Macro: SEVEN_SEG_LEADING_ZERO_SUPPRESS_EN.
- Defined:
  - At commit, digits above the most significant nonzero nibble are added to the effective blank mask.
  - Digit 0 is never suppressed, so value 0 shows a single "0".
- Undefined: all digits are shown, including leading zeros; only i_Blank_Mask blanks digits.

Decomposition:
- Package seven_seg_pkg holds:
  - the 16-entry hex-to-segment constant table (7-bit logical);
  - SEG_OFF constant;
  - state enum {BLANK, DRIVE};
  - a clog2-style width helper.
- Sub-module hex_to_seg7: combinational nibble -> 7-bit logical encoding, using the package table. Polarity inversion stays in the top level.

Test Plan (NUM_DIGITS=4, CLKS_PER_DIGIT=8, DEAD_CLKS=2, both active-low):
- Reset release -> o_Digit_En=4'b1111 and o_Segments=7'h7F for 2 cycles; then o_Digit_En=4'b1110 with o_Segments=~7'h7E for 8 cycles.
- i_Load with i_Value=16'h12AF -> after the next frame wrap, the digits show F,A,2,1 (segments ~47, ~77, ~6D, ~30). o_Frame_Done pulses every 40 cycles.
- Load 16'h1111 mid-frame, then 16'h2222 before the wrap -> the old value finishes the frame unchanged; the next frame shows all "2" (~6D), and 1111 is never displayed.
- i_Load coincident with the wrap cycle, value 16'h0F0F -> committed at that edge; pending_valid=0 afterwards.
- i_Blank_Mask=4'b0100 -> during digit 2's slot o_Digit_En=4'b1011 and o_Segments=7'h7F; the other digits are normal.
- Reset asserted during a DRIVE cycle -> outputs go off asynchronously. After release, scanning restarts at digit 0 showing 0.

Source files
------------

// File: rtl/seven_seg_scan_driver_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared definitions for the seven_seg_scan_driver block:
//   - HEX_SEG_TABLE : 16-entry nibble -> 7-bit logical segment code (A..G = bit6..0)
//   - SEG_OFF       : logical "all segments dark" code
//   - scan_state_t  : scan FSM states {BLANK, DRIVE}
//   - width_for()   : bits needed to hold the values 0..count-1 (minimum 1)
// -----------------------------------------------------------------------------
package seven_seg_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    localparam logic [6:0] SEG_OFF = 7'h00;

    // Packed so that HEX_SEG_TABLE[n] is the code for nibble n; entry F is listed first.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'h47, 7'h4F, 7'h3D, 7'h4E,   // F E d C
        7'h1F, 7'h77, 7'h7B, 7'h7F,   // b A 9 8
        7'h70, 7'h5F, 7'h5B, 7'h33,   // 7 6 5 4
        7'h79, 7'h6D, 7'h30, 7'h7E    // 3 2 1 0
    };

    function automatic int unsigned width_for(input int unsigned count);
        int unsigned w;
        w = 1;
        while ((32'd1 << w) < count) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver_if
// Groups the value-load side and the display-pin side of the scan driver.
//   i_Value      : packed hex digits, digit 0 in bits [3:0]
//   i_Load       : one-cycle strobe capturing i_Value / i_Blank_Mask
//   i_Blank_Mask : 1 = force that digit dark
//   o_Segments   : segment pins, bit6=A .. bit0=G, polarity applied
//   o_Digit_En   : one-hot digit select pins, polarity applied
//   o_Frame_Done : one-cycle pulse in the last drive cycle of the last digit
// Modports: master = the logic supplying values, slave = the scan driver.
// -----------------------------------------------------------------------------
interface seven_seg_scan_driver_if #(
    parameter int unsigned NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] i_Value;
    logic                    i_Load;
    logic [NUM_DIGITS-1:0]   i_Blank_Mask;
    logic [6:0]              o_Segments;
    logic [NUM_DIGITS-1:0]   o_Digit_En;
    logic                    o_Frame_Done;

    modport master (
        output i_Value, i_Load, i_Blank_Mask,
        input  o_Segments, o_Digit_En, o_Frame_Done
    );

    modport slave (
        input  i_Value, i_Load, i_Blank_Mask,
        output o_Segments, o_Digit_En, o_Frame_Done
    );
endinterface

// File: rtl/seven_seg_scan_driver_hex_to_seg7.sv
// -----------------------------------------------------------------------------
// hex_to_seg7
// Combinational nibble -> 7-bit logical segment code (A..G = bit6..0).
// Pin polarity is handled by the caller.
//   i_Nibble : hex digit 0..F
//   o_Seg    : logical segment code (1 = segment lit)
// -----------------------------------------------------------------------------
module hex_to_seg7
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_Nibble,
    output logic [6:0] o_Seg
);
    assign o_Seg = HEX_SEG_TABLE[i_Nibble];
endmodule

// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
// Time-multiplexed N-digit 7-segment driver. Each digit slot is DEAD_CLKS blank
// cycles followed by CLKS_PER_DIGIT drive cycles. Loaded values wait in a
// pending buffer and are committed only on the frame wrap edge, so a frame
// never shows a mix of old and new digits.
//
// Ports:
//   i_Clk    : system clock
//   i_Rst_L  : asynchronous active-low reset
//   io_Bus   : seven_seg_scan_driver_if.slave (value/load/mask in, pins out)
//
// Optional build macro SEVEN_SEG_LEADING_ZERO_SUPPRESS_EN: when defined, digits
// above the most significant nonzero nibble are blanked at commit (digit 0 is
// always shown). When undefined only i_Blank_Mask blanks digits.
// -----------------------------------------------------------------------------
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned CLKS_PER_DIGIT = 25000,
    parameter int unsigned DEAD_CLKS      = 250,
    parameter bit          SEG_ACTIVE_LOW = 1'b1,
    parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst_L,
    seven_seg_scan_driver_if.slave        io_Bus
);

    localparam int unsigned CNT_MAX = (CLKS_PER_DIGIT > DEAD_CLKS) ? CLKS_PER_DIGIT : DEAD_CLKS;
    localparam int unsigned CNT_W   = width_for(CNT_MAX);
    localparam int unsigned IDX_W   = width_for(NUM_DIGITS);
    localparam int unsigned VAL_W   = 4 * NUM_DIGITS;

    localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'(DEAD_CLKS - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(CLKS_PER_DIGIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    localparam logic [6:0]            SEG_PINS_OFF = SEG_ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
    localparam logic [NUM_DIGITS-1:0] DIG_PINS_OFF = DIG_ACTIVE_LOW ? '1 : '0;

    // Scan state
    scan_state_t             r_state;
    logic [CNT_W-1:0]        r_cnt;
    logic [IDX_W-1:0]        r_idx;
    scan_state_t             w_state_next;
    logic [CNT_W-1:0]        w_cnt_next;
    logic [IDX_W-1:0]        w_idx_next;

    // Display / pending buffers
    logic [VAL_W-1:0]        r_display;
    logic [NUM_DIGITS-1:0]   r_disp_mask;
    logic [VAL_W-1:0]        r_pending;
    logic [NUM_DIGITS-1:0]   r_pend_mask;
    logic                    r_pend_valid;

    // Registered pins
    logic [6:0]              r_segments;
    logic [NUM_DIGITS-1:0]   r_digit_en;
    logic                    r_frame_done;

    logic                    w_wrap;
    logic                    w_commit;
    logic [VAL_W-1:0]        w_commit_value;
    logic [NUM_DIGITS-1:0]   w_commit_mask;
    logic [NUM_DIGITS-1:0]   w_lz_mask;

    logic [3:0]              w_nibble;
    logic [6:0]              w_hex_seg;
    logic [6:0]              w_seg_logic;
    logic [NUM_DIGITS-1:0]   w_en_logic;
    logic                    w_frame_done_next;
    logic [6:0]              w_seg_pins;
    logic [NUM_DIGITS-1:0]   w_dig_pins;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 1'b1;
        w_idx_next   = r_idx;
        case (r_state)
            BLANK: begin
                if (r_cnt == DEAD_LAST) begin
                    w_state_next = DRIVE;
                    w_cnt_next   = '0;
                end
            end
            DRIVE: begin
                if (r_cnt == DRIVE_LAST) begin
                    w_state_next = BLANK;
                    w_cnt_next   = '0;
                    w_idx_next   = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
                end
            end
            default: begin
                w_state_next = BLANK;
                w_cnt_next   = '0;
                w_idx_next   = '0;
            end
        endcase
    end

    // Final drive cycle of the last digit: the edge that ends it starts a new frame.
    assign w_wrap = (r_state == DRIVE) && (r_idx == IDX_LAST) && (r_cnt == DRIVE_LAST);

    // A load arriving on the wrap cycle bypasses the pending buffer.
    assign w_commit       = w_wrap && (io_Bus.i_Load || r_pend_valid);
    assign w_commit_value = io_Bus.i_Load ? io_Bus.i_Value      : r_pending;
    assign w_commit_mask  = io_Bus.i_Load ? io_Bus.i_Blank_Mask : r_pend_mask;

`ifdef SEVEN_SEG_LEADING_ZERO_SUPPRESS_EN
    logic w_seen_nonzero;
    always_comb begin
        w_lz_mask      = '0;
        w_seen_nonzero = 1'b0;
        // Walk from the top digit down; digit 0 is deliberately excluded.
        for (int d = NUM_DIGITS - 1; d >= 1; d--) begin
            if (w_commit_value[d*4 +: 4] != 4'h0) begin
                w_seen_nonzero = 1'b1;
            end
            w_lz_mask[d] = ~w_seen_nonzero;
        end
    end
`else
    assign w_lz_mask = '0;
`endif

    // ------------------------------------------------------------------
    // Output decode from the *next* state, so the registered pins line up
    // with the state register without an extra pipeline stage. The display
    // buffer only changes on the wrap edge, which always enters BLANK, so
    // r_display is the right source whenever the next state is DRIVE.
    // ------------------------------------------------------------------
    assign w_nibble = r_display[{w_idx_next, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .i_Nibble (w_nibble),
        .o_Seg    (w_hex_seg)
    );

    always_comb begin
        w_seg_logic       = SEG_OFF;
        w_en_logic        = '0;
        w_frame_done_next = 1'b0;
        if (w_state_next == DRIVE) begin
            w_en_logic        = NUM_DIGITS'(1) << w_idx_next;
            w_seg_logic       = r_disp_mask[w_idx_next] ? SEG_OFF : w_hex_seg;
            w_frame_done_next = (w_idx_next == IDX_LAST) && (w_cnt_next == DRIVE_LAST);
        end
    end

    assign w_seg_pins = SEG_ACTIVE_LOW ? ~w_seg_logic : w_seg_logic;
    assign w_dig_pins = DIG_ACTIVE_LOW ? ~w_en_logic  : w_en_logic;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state      <= BLANK;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_display    <= '0;
            r_disp_mask  <= '0;
            r_pending    <= '0;
            r_pend_mask  <= '0;
            r_pend_valid <= 1'b0;
            r_segments   <= SEG_PINS_OFF;
            r_digit_en   <= DIG_PINS_OFF;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_idx        <= w_idx_next;
            r_segments   <= w_seg_pins;
            r_digit_en   <= w_dig_pins;
            r_frame_done <= w_frame_done_next;

            if (io_Bus.i_Load && !w_wrap) begin
                r_pending    <= io_Bus.i_Value;
                r_pend_mask  <= io_Bus.i_Blank_Mask;
                r_pend_valid <= 1'b1;
            end

            if (w_commit) begin
                r_display    <= w_commit_value;
                r_disp_mask  <= w_commit_mask | w_lz_mask;
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign io_Bus.o_Segments   = r_segments;
    assign io_Bus.o_Digit_En   = r_digit_en;
    assign io_Bus.o_Frame_Done = r_frame_done;

endmodule
